multicycle_add_sub: RTL
=======================

MULTICYCLE_ADD_SUB -- requirements
Module: multicycle_add_sub

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter CHUNK, default 8, bits processed per cycle; WIDTH % CHUNK == 0 and CHUNK <= WIDTH SHALL hold, with an elaboration error otherwise.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operands and op presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 op  input  2  00 ADD, 01 SUB, 10 SLT (signed), 11 SLTU (unsigned).
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH  sum, difference, or compare result zero-extended from bit 0.
REQ-012 cout, overflow, zero, negative  output  1 each  flags of the raw add/sub.

Function
REQ-013 States SHALL be IDLE, BUSY and DONE; N = WIDTH/CHUNK.
REQ-014 IDLE: in_ready=1. in_valid&&in_ready at an edge SHALL register a, b and op, clear the chunk counter, set carry=subtract and enter BUSY.
REQ-015 subtract SHALL be 1 for SUB, SLT and SLTU; b is inverted bitwise when subtract=1 (a + ~b + 1).
REQ-016 BUSY: each edge SHALL add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) with the registered carry, store the sum chunk and the carry, then increment k; after chunk N-1 the state SHALL go to DONE.
REQ-017 out_valid SHALL rise exactly N edges after the accepting edge; in_ready SHALL be 0 in BUSY and DONE.
REQ-018 cout = carry out of the MSB. overflow = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), where b' is the inverted-or-not b. zero = (sum==0). negative = sum[MSB].
REQ-019 SLT result = sum[MSB]^overflow; SLTU result = ~cout; upper WIDTH-1 bits = 0.
REQ-020 Flags SHALL always reflect the raw add/sub, including for SLT and SLTU.
REQ-021 DONE: result and flags SHALL hold stable while out_ready=0; out_valid&&out_ready at an edge SHALL return the state to IDLE.
REQ-022 in_valid arriving outside IDLE SHALL be ignored without side effects; operand changes after acceptance SHALL NOT affect the result.
REQ-023 With CHUNK==WIDTH, N=1 and out_valid SHALL rise one edge after acceptance.

Reset
REQ-024 rst SHALL force IDLE immediately: in_ready=1, out_valid=0, result=0, cout=overflow=zero=negative=0, counter=0, carry=0.
REQ-025 Reset asserted mid-BUSY or in DONE SHALL discard the operation; no out_valid SHALL follow it.

Configuration
REQ-026 Macro MULTICYCLE_ADD_SUB_FLAGS_EN defined: cout, overflow, zero and negative are computed per REQ-018.
REQ-027 Macro undefined: the flag ports remain present but are tied to 0, their flag logic is removed, and SLT/SLTU still compute correctly from internal sign and carry.

Structure
REQ-028 Package add_sub_pkg SHALL hold the op encoding enum (OP_ADD, OP_SUB, OP_SLT, OP_SLTU) and the state enum.
REQ-029 One combinational sub-module, add_sub_chunk (CHUNK-bit a, b, cin -> sum, cout), SHALL be instantiated once and reused every BUSY cycle.

Verification (WIDTH=32, CHUNK=8)
REQ-030 ADD 0xFFFFFFFF + 0x00000001 -> result 0x00000000, cout=1, zero=1, overflow=0; out_valid 4 edges after accept.
REQ-031 SUB 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, overflow=1, negative=0, cout=1.
REQ-032 SLT a=0xFFFFFFFF, b=0x00000001 -> result 1; SLTU with the same operands -> result 0.
REQ-033 Backpressure: out_ready held 0 for 5 cycles after out_valid -> result stable, in_ready=0, a new in_valid is ignored; release -> IDLE next edge.
REQ-034 rst pulsed at the second BUSY edge -> out_valid stays 0, in_ready=1 immediately; a following ADD 3+4 -> result 7.
REQ-035 Run with MULTICYCLE_ADD_SUB_FLAGS_EN undefined: repeat REQ-030 -> flags 0, result 0x00000000; repeat REQ-032 -> same results.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared types for the multicycle add/sub block: operation encoding,
// controller states and a small decode helper.
package add_sub_pkg;

    // Operation encoding as presented on the op port.
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_SLT  = 2'b10,
        OP_SLTU = 2'b11
    } op_e;

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Every operation except ADD is evaluated as a + ~b + 1.
    function automatic logic is_subtract(input op_e o);
        return (o != OP_ADD);
    endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
module add_sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    // Widen by one bit so the carry out falls out of the addition.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    end

endmodule

// File: rtl/multicycle_add_sub.sv
// Multicycle adder/subtractor/comparator. Operands are consumed CHUNK bits
// per cycle through a single reused add_sub_chunk slice; the result is held
// until the consumer takes it.
// Optional feature: define MULTICYCLE_ADD_SUB_FLAGS_EN to drive the
// cout/overflow/zero/negative flag outputs; otherwise they are tied to 0.
module multicycle_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("multicycle_add_sub: CHUNK must divide WIDTH and not exceed it");
        end
    endgenerate

    state_e             state;
    state_e             state_next;
    logic [WIDTH-1:0]   a_r;       // operand a, shifted right one chunk per cycle
    logic [WIDTH-1:0]   b_r;       // b or ~b, shifted the same way
    logic [WIDTH-1:0]   sum_r;     // sum chunks, filled in from the top
    op_e                op_r;
    logic               carry;
    logic [CNT_W-1:0]   k;

    logic [CHUNK-1:0]   chunk_sum;
    logic               chunk_cout;
    logic               accept;
    logic               last_chunk;
    logic [WIDTH-1:0]   sum_next;
    logic               raw_ovf;
    logic               slt_bit;
    logic               sltu_bit;
    logic [WIDTH-1:0]   final_result;

    // The current chunk always sits in the low bits of the shifted operands.
    add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_r[CHUNK-1:0]),
        .b    (b_r[CHUNK-1:0]),
        .cin  (carry),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    assign accept     = (state == S_IDLE) && in_valid;
    assign last_chunk = (k == CNT_W'(N - 1));

    // Assemble the sum and derive the compare bits from the final chunk.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        final_result = '0;
        sum_next     = (sum_r >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
        // On the last chunk the operand MSBs are at bit CHUNK-1 of the shifted registers.
        raw_ovf      = (a_r[CHUNK-1] == b_r[CHUNK-1]) && (chunk_sum[CHUNK-1] != a_r[CHUNK-1]);
        slt_bit      = chunk_sum[CHUNK-1] ^ raw_ovf;
        sltu_bit     = ~chunk_cout;
        case (op_r)
            OP_SLT:  final_result = WIDTH'(slt_bit);
            OP_SLTU: final_result = WIDTH'(sltu_bit);
            default: final_result = sum_next;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid)   state_next = S_BUSY;
            S_BUSY:  if (last_chunk) state_next = S_DONE;
            S_DONE:  if (out_ready)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Operand capture and chunk-serial datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            op_r   <= OP_ADD;
            carry  <= 1'b0;
            k      <= '0;
            result <= '0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= is_subtract(op_e'(op)) ? ~b : b;
            sum_r <= '0;
            op_r  <= op_e'(op);
            carry <= is_subtract(op_e'(op));
            k     <= '0;
        end else if (state == S_BUSY) begin
            a_r   <= a_r >> CHUNK;
            b_r   <= b_r >> CHUNK;
            sum_r <= sum_next;
            carry <= chunk_cout;
            k     <= k + 1'b1;
            if (last_chunk) begin
                result <= final_result;
            end
        end
    end

`ifdef MULTICYCLE_ADD_SUB_FLAGS_EN
    // Flags of the raw add/sub, captured with the final chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (state == S_BUSY && last_chunk) begin
            cout     <= chunk_cout;
            overflow <= raw_ovf;
            zero     <= (sum_next == '0);
            negative <= sum_next[WIDTH-1];
        end
    end
`else
    assign cout     = 1'b0;
    assign overflow = 1'b0;
    assign zero     = 1'b0;
    assign negative = 1'b0;
`endif

endmodule
